// File: rtl/bank_htu_req_issue.sv
// ---------------------------------------------------------------------------
// bank_htu_req_issue
//
// Purpose:
//   Buffers HTU requests (read / write / flush / invalidate) in a small FIFO.
//   Issues them one at a time from a single registered issue stage. Every
//   decoded output comes straight from a flop. The set select is one-hot and
//   is qualified by the issue-stage valid.
//
// Ports:
//   clk_i               - clock
//   rst_i               - asynchronous active-low reset
//   req_valid_i         - upstream request valid
//   req_ready_o         - buffer can accept a request this cycle (registered)
//   req_op_i[1:0]       - 00 read, 01 write, 10 flush, 11 invalidate
//   req_addr_i[31:0]    - byte address: tag [31:10], set [9:6], offset [5]
//   htu_stall_i         - HTU cannot take the presented op this cycle
//   op_is_read_o        - issued op is a read
//   op_is_write_o       - issued op is a write
//   op_is_flush_o       - issued op is a flush
//   op_is_invalidate_o  - issued op is an invalidate
//   set_hit_WV_o[15:0]  - one-hot set select, zero when nothing is issued
//   access_tag_o[21:0]  - tag of the issued op
//   access_offset_o     - half-line offset of the issued op
//   busy_o              - FIFO or issue stage holds an op
//   issue_cnt_o         - running count of issued ops (wraps)
// ---------------------------------------------------------------------------
module bank_htu_req_issue #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [31:0]      req_addr_i,
  input  logic             htu_stall_i,
  output logic             op_is_read_o,
  output logic             op_is_write_o,
  output logic             op_is_flush_o,
  output logic             op_is_invalidate_o,
  output logic [15:0]      set_hit_WV_o,
  output logic [21:0]      access_tag_o,
  output logic             access_offset_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] issue_cnt_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]   FULL_C  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_FL  = 2'b10;
  localparam logic [1:0] OP_INV = 2'b11;

  // Request buffer storage (stage p0); data only, no reset needed.
  logic [1:0]  r_fifo_op_p0  [FIFO_DEPTH];
  logic [21:0] r_fifo_tag_p0 [FIFO_DEPTH];
  logic [3:0]  r_fifo_set_p0 [FIFO_DEPTH];
  logic        r_fifo_off_p0 [FIFO_DEPTH];

  // Buffer control.
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             r_ready;

  // Issue stage (stage p1); all outputs come from these flops.
  logic             r_vld_p1;
  logic             r_rd_p1;
  logic             r_wr_p1;
  logic             r_fl_p1;
  logic             r_inv_p1;
  logic [15:0]      r_set_hit_p1;
  logic [21:0]      r_tag_p1;
  logic             r_off_p1;
  logic [CNT_W-1:0] r_issue_cnt;

  logic             w_push;
  logic             w_pop;
  logic             w_issue;
  logic             w_fifo_nempty;
  logic [PTR_W:0]   w_count_nxt;
  logic [1:0]       w_head_op;
  logic [3:0]       w_head_set;

  assign w_fifo_nempty = (r_count != '0);
  assign w_push        = req_valid_i & r_ready;
  assign w_issue       = r_vld_p1 & ~htu_stall_i;
  // The issue stage refills whenever it is empty or its op leaves this edge.
  assign w_pop         = w_fifo_nempty & (~r_vld_p1 | ~htu_stall_i);
  assign w_head_op     = r_fifo_op_p0[r_head];
  assign w_head_set    = r_fifo_set_p0[r_head];

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // ---- stage p0: request buffer write ----
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_op_p0[r_tail]  <= req_op_i;
      r_fifo_tag_p0[r_tail] <= req_addr_i[31:10];
      r_fifo_set_p0[r_tail] <= req_addr_i[9:6];
      r_fifo_off_p0[r_tail] <= req_addr_i[5];
    end
  end

  // Pointers wrap explicitly so the behaviour does not depend on the depth
  // filling the pointer width exactly.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ready <= 1'b1;
    end else begin
      if (w_push) r_tail <= (r_tail == LAST_C) ? '0 : r_tail + 1'b1;
      if (w_pop)  r_head <= (r_head == LAST_C) ? '0 : r_head + 1'b1;
      r_count <= w_count_nxt;
      // Ready is registered from the post-edge occupancy, so there is no
      // combinational path from req_valid_i.
      r_ready <= (w_count_nxt != FULL_C);
    end
  end

  // ---- stage p1: issue register ----
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_vld_p1     <= 1'b0;
      r_rd_p1      <= 1'b0;
      r_wr_p1      <= 1'b0;
      r_fl_p1      <= 1'b0;
      r_inv_p1     <= 1'b0;
      r_set_hit_p1 <= '0;
      r_tag_p1     <= '0;
      r_off_p1     <= 1'b0;
    end else if (w_pop) begin
      r_vld_p1     <= 1'b1;
      r_rd_p1      <= (w_head_op == OP_RD);
      r_wr_p1      <= (w_head_op == OP_WR);
      r_fl_p1      <= (w_head_op == OP_FL);
      r_inv_p1     <= (w_head_op == OP_INV);
      r_set_hit_p1 <= 16'h0001 << w_head_set;
      r_tag_p1     <= r_fifo_tag_p0[r_head];
      r_off_p1     <= r_fifo_off_p0[r_head];
    end else if (w_issue) begin
      // Op consumed with nothing behind it: clear so gated outputs read zero.
      r_vld_p1     <= 1'b0;
      r_rd_p1      <= 1'b0;
      r_wr_p1      <= 1'b0;
      r_fl_p1      <= 1'b0;
      r_inv_p1     <= 1'b0;
      r_set_hit_p1 <= '0;
      r_tag_p1     <= '0;
      r_off_p1     <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_issue_cnt <= '0;
    end else if (w_issue) begin
      r_issue_cnt <= r_issue_cnt + 1'b1;
    end
  end

  assign req_ready_o        = r_ready;
  assign op_is_read_o       = r_rd_p1;
  assign op_is_write_o      = r_wr_p1;
  assign op_is_flush_o      = r_fl_p1;
  assign op_is_invalidate_o = r_inv_p1;
  assign set_hit_WV_o       = r_set_hit_p1;
  assign access_tag_o       = r_tag_p1;
  assign access_offset_o    = r_off_p1;
  assign busy_o             = w_fifo_nempty | r_vld_p1;
  assign issue_cnt_o        = r_issue_cnt;

endmodule

// File: tb/tb_bank_htu_req_issue.sv
module tb_bank_htu_req_issue;

  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  logic [1:0]       req_op_i = 2'b00;
  logic [31:0]      req_addr_i = 32'h0;
  logic             htu_stall_i = 1'b0;
  logic             op_is_read_o;
  logic             op_is_write_o;
  logic             op_is_flush_o;
  logic             op_is_invalidate_o;
  logic [15:0]      set_hit_WV_o;
  logic [21:0]      access_tag_o;
  logic             access_offset_o;
  logic             busy_o;
  logic [CNT_W-1:0] issue_cnt_o;

  int n_chk  = 0;
  int n_pass = 0;

  bank_htu_req_issue #(.FIFO_DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_op_i           (req_op_i),
    .req_addr_i         (req_addr_i),
    .htu_stall_i        (htu_stall_i),
    .op_is_read_o       (op_is_read_o),
    .op_is_write_o      (op_is_write_o),
    .op_is_flush_o      (op_is_flush_o),
    .op_is_invalidate_o (op_is_invalidate_o),
    .set_hit_WV_o       (set_hit_WV_o),
    .access_tag_o       (access_tag_o),
    .access_offset_o    (access_offset_o),
    .busy_o             (busy_o),
    .issue_cnt_o        (issue_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled
  // 1 ns after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] addr);
    req_valid_i = v;
    req_op_i    = op;
    req_addr_i  = addr;
  endtask

  task automatic ops_vec(input string tag, input logic [3:0] exp);
    chk(tag, {28'h0, op_is_read_o, op_is_write_o, op_is_flush_o, op_is_invalidate_o}, {28'h0, exp});
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    drive(1'b0, 2'b00, 32'h0);
    htu_stall_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #1;
    tick();
    chk("rst_ready", {31'h0, req_ready_o}, 32'h1);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_cnt", {28'h0, issue_cnt_o}, 32'h0);
    chk("rst_set", {16'h0, set_hit_WV_o}, 32'h0);
    ops_vec("rst_ops", 4'b0000);
    rst_i = 1'b1;

    // ---------------- single read ----------------
    drive(1'b1, 2'b00, 32'h0000_0A60);
    tick();                              // edge N: accepted
    drive(1'b0, 2'b00, 32'h0);
    chk("rd_busy_n", {31'h0, busy_o}, 32'h1);
    ops_vec("rd_ops_n", 4'b0000);
    tick();                              // edge N+1: in issue stage
    ops_vec("rd_ops", 4'b1000);
    chk("rd_set", {16'h0, set_hit_WV_o}, 32'h0200);
    chk("rd_tag", {10'h0, access_tag_o}, 32'h2);
    chk("rd_off", {31'h0, access_offset_o}, 32'h1);
    chk("rd_cnt_pre", {28'h0, issue_cnt_o}, 32'h0);
    tick();
    chk("rd_cnt", {28'h0, issue_cnt_o}, 32'h1);
    chk("rd_set_idle", {16'h0, set_hit_WV_o}, 32'h0);
    chk("rd_busy_idle", {31'h0, busy_o}, 32'h0);

    // ---------------- back-to-back writes ----------------
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, 2'b01, 32'(i) << 6);
      else       drive(1'b0, 2'b00, 32'h0);
      tick();
      if (i < 4) chk("b2b_ready", {31'h0, req_ready_o}, 32'h1);
      if (i >= 1 && i <= 4) begin
        chk("b2b_set", {16'h0, set_hit_WV_o}, 32'h1 << (i - 1));
        ops_vec("b2b_ops", 4'b0100);
      end
    end
    chk("b2b_cnt", {28'h0, issue_cnt_o}, 32'h4);
    chk("b2b_busy", {31'h0, busy_o}, 32'h0);

    // ---------------- stall and full ----------------
    do_reset();
    htu_stall_i = 1'b1;
    drive(1'b1, 2'b00, 32'h0000_0040);  // A: read, set 1
    tick();
    chk("st_ready1", {31'h0, req_ready_o}, 32'h1);
    drive(1'b1, 2'b01, 32'h0000_0080);  // B: write, set 2
    tick();
    chk("st_ready2", {31'h0, req_ready_o}, 32'h1);
    chk("st_setA", {16'h0, set_hit_WV_o}, 32'h0002);
    drive(1'b1, 2'b10, 32'h0000_00C0);  // C: flush, set 3
    tick();
    chk("st_full", {31'h0, req_ready_o}, 32'h0);
    chk("st_holdA", {16'h0, set_hit_WV_o}, 32'h0002);
    drive(1'b1, 2'b11, 32'h0000_0100);  // D: must be refused while full
    tick();
    chk("st_full2", {31'h0, req_ready_o}, 32'h0);
    ops_vec("st_holdA_ops", 4'b1000);
    chk("st_cnt0", {28'h0, issue_cnt_o}, 32'h0);
    htu_stall_i = 1'b0;
    tick();                              // A issues, B loads
    drive(1'b0, 2'b00, 32'h0);
    chk("st_cnt1", {28'h0, issue_cnt_o}, 32'h1);
    chk("st_setB", {16'h0, set_hit_WV_o}, 32'h0004);
    chk("st_ready_back", {31'h0, req_ready_o}, 32'h1);
    tick();
    chk("st_setC", {16'h0, set_hit_WV_o}, 32'h0008);
    ops_vec("st_opsC", 4'b0010);
    chk("st_cnt2", {28'h0, issue_cnt_o}, 32'h2);
    tick();
    chk("st_cnt3", {28'h0, issue_cnt_o}, 32'h3);
    chk("st_noD", {31'h0, busy_o}, 32'h0);

    // ---------------- flush then invalidate ----------------
    do_reset();
    drive(1'b1, 2'b10, 32'h0000_0A60);
    tick();
    drive(1'b1, 2'b11, 32'h0000_0A60);
    tick();
    drive(1'b0, 2'b00, 32'h0);
    ops_vec("mix_flush", 4'b0010);
    tick();
    ops_vec("mix_inv", 4'b0001);
    chk("mix_set", {16'h0, set_hit_WV_o}, 32'h0200);
    tick();
    ops_vec("mix_idle", 4'b0000);
    chk("mix_cnt", {28'h0, issue_cnt_o}, 32'h2);

    // ---------------- reset mid-stream ----------------
    htu_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b01, 32'(i + 4) << 6);
      tick();
    end
    drive(1'b0, 2'b00, 32'h0);
    chk("mr_busy_pre", {31'h0, busy_o}, 32'h1);
    chk("mr_full_pre", {31'h0, req_ready_o}, 32'h0);
    rst_i = 1'b0;
    #1;
    ops_vec("mr_ops", 4'b0000);
    chk("mr_set", {16'h0, set_hit_WV_o}, 32'h0);
    chk("mr_busy", {31'h0, busy_o}, 32'h0);
    chk("mr_cnt", {28'h0, issue_cnt_o}, 32'h0);
    chk("mr_ready", {31'h0, req_ready_o}, 32'h1);
    tick();
    rst_i = 1'b1;
    htu_stall_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_after_busy", {31'h0, busy_o}, 32'h0);
      chk("mr_after_cnt", {28'h0, issue_cnt_o}, 32'h0);
    end

    // ---------------- counter wrap (CNT_W=4, 17 ops) ----------------
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 2'b00, 32'(i % 16) << 6);
      tick();
    end
    drive(1'b0, 2'b00, 32'h0);
    tick();
    tick();
    tick();
    chk("wrap_cnt", {28'h0, issue_cnt_o}, 32'h1);
    chk("wrap_busy", {31'h0, busy_o}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
